apb_cmd_sequencer: RTL

Upstream command stage for the APB `master`: accepts host commands (read/write, address, data, slave function code) into a small FIFO and drives the `master` request inputs one transfer at a time. It waits for APB completion and returns one response per command, with captured read data. It keeps the `master`/`slave` pair busy without host cycle-level sequencing, and replaces the hand-driven PSEL/PADDR/PDATA stimulus used so far.

---
 rtl/apb_seq_pkg.sv | 21 ++
 rtl/apb_cmd_fifo.sv | 62 ++++++
 rtl/apb_cmd_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/apb_seq_pkg.sv
// Shared types and default parameters for the APB command sequencer and its FIFO.
package apb_seq_pkg;

    localparam int unsigned DEFAULT_DEPTH   = 4;
    localparam int unsigned DEFAULT_GAP     = 1;
    localparam int unsigned DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  f;
    } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; the head entry is visible combinationally so the
// sequencer can pop and load the APB request registers on the same edge.
module apb_cmd_fifo
    import apb_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  apb_cmd_t push_data,
    input  logic     pop,
    output apb_cmd_t head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    apb_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // A push is refused when full even if a pop happens on the same edge.
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Queues host commands and issues them to the APB master one transfer at a time,
// returning one response per command. Optional watchdog: APB_SEQ_TIMEOUT_EN.
module apb_cmd_sequencer
    import apb_seq_pkg::state_t;
    import apb_seq_pkg::apb_cmd_t;
    import apb_seq_pkg::IDLE;
    import apb_seq_pkg::BUSY;
    import apb_seq_pkg::DEFAULT_DEPTH;
    import apb_seq_pkg::DEFAULT_GAP;
    import apb_seq_pkg::DEFAULT_TIMEOUT;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned GAP     = DEFAULT_GAP,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [1:0]  cmd_f,
    output logic        PSEL,
    output logic        transfer,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PDATA,
    output logic [1:0]  f,
    input  logic        PENABLE,
    input  logic        PREADY,
    input  logic [31:0] PRDATA1,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int unsigned GAP_W = $clog2(GAP + 1);

    apb_cmd_t    push_cmd;
    apb_cmd_t    head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        done;
    logic        timeout;

    state_t      state_reg, state_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic        psel_reg, psel_next;
    logic        pwrite_reg, pwrite_next;
    logic [31:0] paddr_reg, paddr_next;
    logic [31:0] pdata_reg, pdata_next;
    logic [1:0]  f_reg, f_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic        rsp_write_reg, rsp_write_next;
    logic [31:0] rsp_data_reg, rsp_data_next;

    assign push_cmd = '{write: cmd_write, addr: cmd_addr, data: cmd_data, f: cmd_f};

    // Held low while reset is asserted so the host sees no readiness until release.
    assign cmd_ready = ~fifo_full & ~PRESET;
    assign pop       = (state_reg == IDLE) & ~fifo_empty;
    assign done      = (state_reg == BUSY) & psel_reg & PENABLE & PREADY;

    apb_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (PCLK),
        .rst      (PRESET),
        .push     (cmd_valid),
        .push_data(push_cmd),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef APB_SEQ_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer_reg;
    logic             rsp_err_reg;

    // Timer is zero on the edge PSEL rises and reaches TIMEOUT-1 on the TIMEOUT-th busy edge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            timer_reg   <= '0;
            rsp_err_reg <= 1'b0;
        end else begin
            rsp_err_reg <= timeout & ~done;
            if (state_reg != BUSY) begin
                timer_reg <= '0;
            end else begin
                timer_reg <= timer_reg + TMR_W'(1);
            end
        end
    end

    assign timeout = (state_reg == BUSY) && (timer_reg == TMR_W'(TIMEOUT - 1));
    assign rsp_err = rsp_err_reg;
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg     <= IDLE;
            gap_cnt_reg   <= '0;
            psel_reg      <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pdata_reg     <= '0;
            f_reg         <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_write_reg <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            gap_cnt_reg   <= gap_cnt_next;
            psel_reg      <= psel_next;
            pwrite_reg    <= pwrite_next;
            paddr_reg     <= paddr_next;
            pdata_reg     <= pdata_next;
            f_reg         <= f_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_write_reg <= rsp_write_next;
            rsp_data_reg  <= rsp_data_next;
        end
    end

    // The GAP state literal is package-qualified because the GAP parameter shadows it.
    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (done || timeout) begin
                    state_next   = apb_seq_pkg::GAP;
                    gap_cnt_next = '0;
                end
            end
            apb_seq_pkg::GAP: begin
                if (gap_cnt_reg == GAP_W'(GAP - 1)) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields keep their last values until the next pop; a completion
    // coinciding with the watchdog expiry is reported as a success.
    always_comb begin
        psel_next      = psel_reg;
        pwrite_next    = pwrite_reg;
        paddr_next     = paddr_reg;
        pdata_next     = pdata_reg;
        f_next         = f_reg;
        rsp_valid_next = 1'b0;
        rsp_write_next = rsp_write_reg;
        rsp_data_next  = rsp_data_reg;
        if (pop) begin
            psel_next   = 1'b1;
            pwrite_next = head.write;
            paddr_next  = head.addr;
            pdata_next  = head.data;
            f_next      = head.f;
        end
        if (done || timeout) begin
            psel_next      = 1'b0;
            rsp_valid_next = 1'b1;
            rsp_write_next = pwrite_reg;
            rsp_data_next  = (pwrite_reg || !done) ? 32'h0 : PRDATA1;
        end
    end

    assign PSEL      = psel_reg;
    assign transfer  = psel_reg;
    assign PWRITE    = pwrite_reg;
    assign PADDR     = paddr_reg;
    assign PDATA     = pdata_reg;
    assign f         = f_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_write = rsp_write_reg;
    assign rsp_data  = rsp_data_reg;

endmodule
